// File: rtl/card_decode_pipe.sv
// Card word decoder: splits packed card words into registered fields behind a
// one-deep valid/ready register. Running turn totals need CARD_DECODE_TOTALS_EN.
module card_decode_pipe #(
  parameter int GOLD_W   = 5,
  parameter int BUY_W    = 3,
  parameter int ACTION_W = 3,
  parameter int DRAW_W   = 3,
  parameter int VP_W     = 4,
  parameter int COST_W   = 4,
  parameter int NAME_W   = 8,
  parameter int TOT_W    = 8,
  localparam int CARD_W  = GOLD_W + BUY_W + ACTION_W + DRAW_W + VP_W + COST_W + NAME_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                turn_start,
  input  logic                turn_end,
  input  logic                endgame,
  input  logic [CARD_W-1:0]   card_data,
  input  logic                card_valid,
  output logic                card_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [GOLD_W-1:0]   gold,
  output logic [BUY_W-1:0]    buy,
  output logic [ACTION_W-1:0] action,
  output logic [DRAW_W-1:0]   draw,
  output logic [VP_W-1:0]     vp,
  output logic [COST_W-1:0]   cost,
  output logic [NAME_W-1:0]   name,
  output logic [TOT_W-1:0]    total_gold,
  output logic [TOT_W-1:0]    total_buy,
  output logic [TOT_W-1:0]    total_action,
  output logic [TOT_W-1:0]    total_draw,
  output logic [TOT_W-1:0]    total_vp,
  output logic [TOT_W-1:0]    card_count,
  output logic                turn_done,
  output logic                busy
);

  localparam int COST_LSB = NAME_W;
  localparam int VP_LSB   = COST_LSB + COST_W;
  localparam int DRAW_LSB = VP_LSB + VP_W;
  localparam int ACT_LSB  = DRAW_LSB + DRAW_W;
  localparam int BUY_LSB  = ACT_LSB + ACTION_W;
  localparam int GOLD_LSB = BUY_LSB + BUY_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TURN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   ready;
  logic   accept;
  logic   clear_tot;

  logic                out_valid_q, out_valid_d;
  logic [GOLD_W-1:0]   gold_q, gold_d;
  logic [BUY_W-1:0]    buy_q, buy_d;
  logic [ACTION_W-1:0] action_q, action_d;
  logic [DRAW_W-1:0]   draw_q, draw_d;
  logic [VP_W-1:0]     vp_q, vp_d;
  logic [COST_W-1:0]   cost_q, cost_d;
  logic [NAME_W-1:0]   name_q, name_d;

  // Turn control: turn_end outranks turn_start, a restart inside TURN clears totals
  always_comb begin
    state_d   = state_q;
    ready     = 1'b0;
    clear_tot = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (turn_start) begin
          state_d   = S_TURN;
          clear_tot = 1'b1;
        end
      end
      S_TURN: begin
        ready = !out_valid_q || out_ready;
        if (turn_end) begin
          state_d = S_DONE;
        end else if (turn_start) begin
          clear_tot = 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign accept     = card_valid && ready;
  assign card_ready = ready;
  assign busy       = (state_q == S_TURN);
  assign turn_done  = (state_q == S_DONE);

  // Output register: load on accept, otherwise hold until the consumer drains it
  always_comb begin
    out_valid_d = out_valid_q;
    gold_d      = gold_q;
    buy_d       = buy_q;
    action_d    = action_q;
    draw_d      = draw_q;
    vp_d        = vp_q;
    cost_d      = cost_q;
    name_d      = name_q;
    if (accept) begin
      out_valid_d = 1'b1;
      gold_d      = card_data[GOLD_LSB +: GOLD_W];
      buy_d       = card_data[BUY_LSB +: BUY_W];
      action_d    = card_data[ACT_LSB +: ACTION_W];
      draw_d      = card_data[DRAW_LSB +: DRAW_W];
      vp_d        = card_data[VP_LSB +: VP_W];
      cost_d      = card_data[COST_LSB +: COST_W];
      name_d      = card_data[NAME_W-1:0];
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      gold_q      <= '0;
      buy_q       <= '0;
      action_q    <= '0;
      draw_q      <= '0;
      vp_q        <= '0;
      cost_q      <= '0;
      name_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      gold_q      <= gold_d;
      buy_q       <= buy_d;
      action_q    <= action_d;
      draw_q      <= draw_d;
      vp_q        <= vp_d;
      cost_q      <= cost_d;
      name_q      <= name_d;
    end
  end

  assign out_valid = out_valid_q;
  assign gold      = gold_q;
  assign buy       = buy_q;
  assign action    = action_q;
  assign draw      = draw_q;
  assign vp        = vp_q;
  assign cost      = cost_q;
  assign name      = name_q;

`ifdef CARD_DECODE_TOTALS_EN
  // Wide enough that gold+vp plus any running total can never wrap before the clamp
  localparam int SUM_W = TOT_W + GOLD_W + VP_W;
  localparam logic [TOT_W-1:0] TOT_MAX = '1;

  function automatic logic [TOT_W-1:0] sat_add(input logic [TOT_W-1:0] acc,
                                                input logic [SUM_W-1:0] inc);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(acc) + inc;
    if (sum > SUM_W'(TOT_MAX)) begin
      return TOT_MAX;
    end
    return sum[TOT_W-1:0];
  endfunction

  logic [SUM_W-1:0] inc_gold, inc_buy, inc_action, inc_draw, inc_vp;
  logic [TOT_W-1:0] tot_gold_q, tot_gold_d;
  logic [TOT_W-1:0] tot_buy_q, tot_buy_d;
  logic [TOT_W-1:0] tot_action_q, tot_action_d;
  logic [TOT_W-1:0] tot_draw_q, tot_draw_d;
  logic [TOT_W-1:0] tot_vp_q, tot_vp_d;
  logic [TOT_W-1:0] count_q, count_d;

  // Totals step on the same edge as the field register; a restart keeps only this card
  always_comb begin
    inc_buy    = SUM_W'(card_data[BUY_LSB +: BUY_W]);
    inc_action = SUM_W'(card_data[ACT_LSB +: ACTION_W]);
    inc_draw   = SUM_W'(card_data[DRAW_LSB +: DRAW_W]);
    if (endgame) begin
      inc_gold = '0;
      inc_vp   = SUM_W'(card_data[GOLD_LSB +: GOLD_W]) + SUM_W'(card_data[VP_LSB +: VP_W]);
    end else begin
      inc_gold = SUM_W'(card_data[GOLD_LSB +: GOLD_W]);
      inc_vp   = SUM_W'(card_data[VP_LSB +: VP_W]);
    end
    tot_gold_d   = clear_tot ? '0 : tot_gold_q;
    tot_buy_d    = clear_tot ? '0 : tot_buy_q;
    tot_action_d = clear_tot ? '0 : tot_action_q;
    tot_draw_d   = clear_tot ? '0 : tot_draw_q;
    tot_vp_d     = clear_tot ? '0 : tot_vp_q;
    count_d      = clear_tot ? '0 : count_q;
    if (accept) begin
      tot_gold_d   = sat_add(tot_gold_d, inc_gold);
      tot_buy_d    = sat_add(tot_buy_d, inc_buy);
      tot_action_d = sat_add(tot_action_d, inc_action);
      tot_draw_d   = sat_add(tot_draw_d, inc_draw);
      tot_vp_d     = sat_add(tot_vp_d, inc_vp);
      count_d      = sat_add(count_d, SUM_W'(1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tot_gold_q   <= '0;
      tot_buy_q    <= '0;
      tot_action_q <= '0;
      tot_draw_q   <= '0;
      tot_vp_q     <= '0;
      count_q      <= '0;
    end else begin
      tot_gold_q   <= tot_gold_d;
      tot_buy_q    <= tot_buy_d;
      tot_action_q <= tot_action_d;
      tot_draw_q   <= tot_draw_d;
      tot_vp_q     <= tot_vp_d;
      count_q      <= count_d;
    end
  end

  assign total_gold   = tot_gold_q;
  assign total_buy    = tot_buy_q;
  assign total_action = tot_action_q;
  assign total_draw   = tot_draw_q;
  assign total_vp     = tot_vp_q;
  assign card_count   = count_q;
`else
  logic unused_totals_ctl;
  assign unused_totals_ctl = endgame | clear_tot;

  assign total_gold   = '0;
  assign total_buy    = '0;
  assign total_action = '0;
  assign total_draw   = '0;
  assign total_vp     = '0;
  assign card_count   = '0;
`endif

endmodule

// File: tb/tb_card_decode_pipe.sv
// Bench for card_decode_pipe: a default-width instance and a TOT_W=4 instance share
// stimulus; a turn-level model plus directed literal expectations check both.
module tb_card_decode_pipe;

`ifdef CARD_DECODE_TOTALS_EN
  localparam bit TOT_EN = 1'b1;
`else
  localparam bit TOT_EN = 1'b0;
`endif

`define CHK(n, a, e) chk(n, 64'(a), 64'(e))

  logic clk = 1'b0;
  logic rst, turn_start, turn_end, endgame, card_valid, out_ready;
  logic [29:0] card_data;

  logic       card_ready, out_valid, turn_done, busy;
  logic [4:0] gold;
  logic [2:0] buy, action, draw;
  logic [3:0] vp, cost;
  logic [7:0] name;
  logic [7:0] total_gold, total_buy, total_action, total_draw, total_vp, card_count;

  logic       card_ready4, out_valid4, turn_done4, busy4;
  logic [4:0] gold4;
  logic [2:0] buy4, action4, draw4;
  logic [3:0] vp4, cost4;
  logic [7:0] name4;
  logic [3:0] total_gold4, total_buy4, total_action4, total_draw4, total_vp4, card_count4;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  card_decode_pipe dut (
    .clk(clk), .rst(rst), .turn_start(turn_start), .turn_end(turn_end),
    .endgame(endgame), .card_data(card_data), .card_valid(card_valid),
    .card_ready(card_ready), .out_valid(out_valid), .out_ready(out_ready),
    .gold(gold), .buy(buy), .action(action), .draw(draw), .vp(vp), .cost(cost),
    .name(name), .total_gold(total_gold), .total_buy(total_buy),
    .total_action(total_action), .total_draw(total_draw), .total_vp(total_vp),
    .card_count(card_count), .turn_done(turn_done), .busy(busy)
  );

  card_decode_pipe #(.TOT_W(4)) dut4 (
    .clk(clk), .rst(rst), .turn_start(turn_start), .turn_end(turn_end),
    .endgame(endgame), .card_data(card_data), .card_valid(card_valid),
    .card_ready(card_ready4), .out_valid(out_valid4), .out_ready(out_ready),
    .gold(gold4), .buy(buy4), .action(action4), .draw(draw4), .vp(vp4), .cost(cost4),
    .name(name4), .total_gold(total_gold4), .total_buy(total_buy4),
    .total_action(total_action4), .total_draw(total_draw4), .total_vp(total_vp4),
    .card_count(card_count4), .turn_done(turn_done4), .busy(busy4)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [29:0] mk(input int g, input int b, input int a, input int d,
                                     input int v, input int c, input int n);
    return {5'(g), 3'(b), 3'(a), 3'(d), 4'(v), 4'(c), 8'(n)};
  endfunction

  function automatic int te(input int v);
    return TOT_EN ? v : 0;
  endfunction

  // Saturating totals equal the clamped true sum because every increment is non-negative.
  function automatic int sat(input int raw, input int w);
    int mx;
    mx = (1 << w) - 1;
    return TOT_EN ? ((raw > mx) ? mx : raw) : 0;
  endfunction

  // Turn-level model: phase flags, one held word, unbounded raw sums
  bit          m_turn = 0, m_done = 0, m_vld = 0;
  bit          m_acc, m_clr;
  logic [29:0] m_word = '0;
  int          r_g = 0, r_b = 0, r_a = 0, r_d = 0, r_v = 0, r_c = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_turn = 0; m_done = 0; m_vld = 0; m_word = '0;
      r_g = 0; r_b = 0; r_a = 0; r_d = 0; r_v = 0; r_c = 0;
    end else begin
      m_acc = m_turn && (!m_vld || out_ready) && card_valid;
      m_clr = turn_start && ((!m_turn && !m_done) || (m_turn && !turn_end));
      if (m_clr) begin
        r_g = 0; r_b = 0; r_a = 0; r_d = 0; r_v = 0; r_c = 0;
      end
      if (m_acc) begin
        if (endgame) r_v += int'(card_data[29:25]) + int'(card_data[15:12]);
        else begin
          r_g += int'(card_data[29:25]);
          r_v += int'(card_data[15:12]);
        end
        r_b += int'(card_data[24:22]);
        r_a += int'(card_data[21:19]);
        r_d += int'(card_data[18:16]);
        r_c += 1;
        m_vld = 1; m_word = card_data;
      end else if (m_vld && out_ready) begin
        m_vld = 0;
      end
      if (m_done) m_done = 0;
      else if (m_turn && turn_end) begin m_turn = 0; m_done = 1; end
      else if (!m_turn && turn_start) m_turn = 1;
    end
  end

  always @(negedge clk) begin
    `CHK("ready", card_ready, m_turn && (!m_vld || out_ready));
    `CHK("out_valid", out_valid, m_vld);
    `CHK("busy", busy, m_turn);
    `CHK("turn_done", turn_done, m_done);
    `CHK("fields", {gold, buy, action, draw, vp, cost, name}, m_word);
    `CHK("total_gold", total_gold, sat(r_g, 8));
    `CHK("total_buy", total_buy, sat(r_b, 8));
    `CHK("total_action", total_action, sat(r_a, 8));
    `CHK("total_draw", total_draw, sat(r_d, 8));
    `CHK("total_vp", total_vp, sat(r_v, 8));
    `CHK("card_count", card_count, sat(r_c, 8));
    `CHK("ctl4", {card_ready4, out_valid4, busy4, turn_done4},
         {m_turn && (!m_vld || out_ready), m_vld, m_turn, m_done});
    `CHK("fields4", {gold4, buy4, action4, draw4, vp4, cost4, name4}, m_word);
    `CHK("totals4", {total_gold4, total_buy4, total_action4, total_draw4, total_vp4},
         {4'(sat(r_g, 4)), 4'(sat(r_b, 4)), 4'(sat(r_a, 4)), 4'(sat(r_d, 4)), 4'(sat(r_v, 4))});
    `CHK("card_count4", card_count4, sat(r_c, 4));
    n_chk++;
    if (out_valid !== m_vld) begin
      n_fail++;
      $display("FAIL out_valid_model: actual=%0d required=%0d at %0t", out_valid, m_vld, $time);
    end
    n_chk++;
    if (card_ready !== (m_turn && (!m_vld || out_ready))) begin
      n_fail++;
      $display("FAIL ready_model: actual=%0d required=%0d at %0t", card_ready,
               m_turn && (!m_vld || out_ready), $time);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; turn_start = 0; turn_end = 0; endgame = 0;
    card_valid = 0; out_ready = 0; card_data = '0;
    repeat (2) tick();
    `CHK("rst_out_valid", out_valid, 0);
    `CHK("rst_busy", busy, 0);
    `CHK("rst_ready", card_ready, 0);
    `CHK("rst_count", card_count, 0);
    rst = 1'b0;
    tick();

    // IDLE ignores cards and turn_end
    card_valid = 1; turn_end = 1; card_data = mk(1, 1, 1, 1, 1, 1, 1);
    tick();
    `CHK("idle_ready", card_ready, 0);
    `CHK("idle_out_valid", out_valid, 0);
    card_valid = 0; turn_end = 0;

    // First card, one-cycle latency
    turn_start = 1; tick(); turn_start = 0;
    `CHK("turn_busy", busy, 1);
    out_ready = 1; card_valid = 1; card_data = 30'h0A5C_5104;
    #1;
    `CHK("turn_ready", card_ready, 1);
    tick();
    card_valid = 0;
    `CHK("c1_gold", gold, 5);
    n_chk++;
    if (gold !== 5'd5) begin
      n_fail++;
      $display("FAIL c1_gold_direct: actual=%0d required=5 at %0t", gold, $time);
    end
    `CHK("c1_buy", buy, 1);
    `CHK("c1_action", action, 3);
    `CHK("c1_draw", draw, 4);
    `CHK("c1_vp", vp, 5);
    `CHK("c1_cost", cost, 1);
    `CHK("c1_name", name, 8'h04);
    `CHK("c1_total_gold", total_gold, te(5));
    `CHK("c1_count", card_count, te(1));

    // Back-pressure holds the first card, second card waits
    out_ready = 0; card_valid = 1; card_data = mk(7, 2, 0, 1, 3, 9, 8'hA5);
    #1;
    `CHK("stall_ready", card_ready, 0);
    tick();
    `CHK("hold_gold", gold, 5);
    tick();
    `CHK("hold_name", name, 8'h04);
    `CHK("hold_valid", out_valid, 1);
    out_ready = 1;
    #1;
    `CHK("release_ready", card_ready, 1);
    tick();
    card_valid = 0;
    `CHK("c2_gold", gold, 7);
    `CHK("c2_name", name, 8'hA5);
    `CHK("c2_cost", cost, 9);
    `CHK("c2_total_gold", total_gold, te(12));
    `CHK("c2_total_buy", total_buy, te(3));
    `CHK("c2_count", card_count, te(2));
    tick();
    `CHK("drain_valid", out_valid, 0);

    // Mixed valid/ready traffic
    for (int i = 0; i < 24; i++) begin
      card_valid = (i % 4) != 3;
      out_ready  = (i % 3) != 2;
      card_data  = mk(i % 32, i % 8, (i * 3) % 8, (i * 5) % 8, i % 16, 15 - (i % 16), i * 11);
      tick();
    end
    card_valid = 0; out_ready = 1;
    tick();

    // Restart with a same-cycle accept keeps only that card
    turn_start = 1; card_valid = 1; card_data = mk(4, 2, 1, 3, 6, 0, 8'h3C);
    tick();
    turn_start = 0; card_valid = 0;
    `CHK("rs_count", card_count, te(1));
    `CHK("rs_gold", total_gold, te(4));
    `CHK("rs_buy", total_buy, te(2));
    `CHK("rs_action", total_action, te(1));
    `CHK("rs_draw", total_draw, te(3));
    `CHK("rs_vp", total_vp, te(6));
    tick();

    // Endgame gold counts as VP
    turn_start = 1; tick(); turn_start = 0;
    `CHK("clr_count", card_count, 0);
    endgame = 1; card_valid = 1; card_data = mk(3, 0, 0, 0, 2, 0, 0);
    tick();
    endgame = 0; card_valid = 0;
    `CHK("eg_vp", total_vp, te(5));
    `CHK("eg_gold", total_gold, 0);

    // turn_start with turn_end: close wins, card on that cycle counts
    turn_start = 1; turn_end = 1; card_valid = 1; card_data = mk(1, 1, 1, 1, 1, 1, 1);
    tick();
    turn_start = 0; turn_end = 0;
    `CHK("done_pulse", turn_done, 1);
    `CHK("done_ready", card_ready, 0);
    `CHK("done_count", card_count, te(2));
    `CHK("done_vp", total_vp, te(6));
    tick();
    card_valid = 0;
    `CHK("done_one_cycle", turn_done, 0);
    `CHK("idle_busy", busy, 0);
    repeat (3) tick();
    `CHK("held_vp", total_vp, te(6));
    `CHK("held_gold", total_gold, te(1));
    turn_start = 1; tick(); turn_start = 0;
    `CHK("new_vp", total_vp, 0);
    `CHK("new_count", card_count, 0);

    // 20 buy cards: the 4-bit totals pin at 15
    card_valid = 1; card_data = mk(0, 1, 0, 0, 0, 0, 0);
    repeat (20) tick();
    card_valid = 0;
    `CHK("buy20", total_buy, te(20));
    `CHK("count20", card_count, te(20));
    `CHK("buy20_w4", total_buy4, te(15));
    `CHK("count20_w4", card_count4, te(15));

    // Saturation at 255 on default widths
    turn_start = 1; tick(); turn_start = 0;
    card_valid = 1; card_data = mk(31, 7, 7, 7, 15, 15, 255);
    repeat (9) tick();
    endgame = 1;
    repeat (3) tick();
    endgame = 0; card_valid = 0;
    `CHK("sat_gold", total_gold, te(255));
    `CHK("sat_vp", total_vp, te(255));
    `CHK("sat_buy", total_buy, te(84));
    `CHK("sat_count", card_count, te(12));
    `CHK("sat_gold_w4", total_gold4, te(15));

    // Asynchronous reset mid-turn with a held word
    out_ready = 0;
    tick();
    `CHK("pre_rst_valid", out_valid, 1);
    #2;
    rst = 1;
    #1;
    `CHK("arst_valid", out_valid, 0);
    `CHK("arst_gold", gold, 0);
    `CHK("arst_name", name, 0);
    `CHK("arst_buy_total", total_buy, 0);
    `CHK("arst_count", card_count, 0);
    `CHK("arst_busy", busy, 0);
    `CHK("arst_ready", card_ready, 0);
    tick();
    rst = 0; out_ready = 1;
    tick();

    // Normal operation after reset
    turn_start = 1; tick(); turn_start = 0;
    card_valid = 1; card_data = 30'h0A5C_5104;
    tick();
    card_valid = 0;
    `CHK("post_gold", gold, 5);
    `CHK("post_count", card_count, te(1));
    turn_end = 1; tick(); turn_end = 0;
    `CHK("post_done", turn_done, 1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/card_decode_pipe.md
CARD_DECODE_PIPE -- requirements
Module: card_decode_pipe

Interface
REQ-001 Parameter GOLD_W, default 5, width of the gold/endgame-VP field.
REQ-002 Parameter BUY_W, default 3; ACTION_W, default 3; DRAW_W, default 3: widths of the buy, action and draw fields.
REQ-003 Parameter VP_W, default 4; COST_W, default 4; NAME_W, default 8: widths of the VP, cost and name fields.
REQ-004 Parameter TOT_W, default 8, width of every running total and of card_count.
REQ-005 Derived CARD_W = GOLD_W+BUY_W+ACTION_W+DRAW_W+VP_W+COST_W+NAME_W (30 at defaults); packing MSB->LSB {gold, buy, action, draw, vp, cost, name}.
REQ-006 Ports, in order name, direction, width, meaning:
clk  in  1  single clock, rising edge.
rst  in  1  asynchronous, active-high reset.
turn_start  in  1  pulse; opens a turn and clears totals.
turn_end  in  1  pulse; closes the current turn.
endgame  in  1  gold field counts as VP for cards accepted while high.
card_data  in  CARD_W  packed card word from card RAM.
card_valid  in  1  card_data valid.
card_ready  out  1  block accepts card_data this cycle.
out_valid  out  1  decoded fields valid.
out_ready  in  1  consumer takes the decoded fields.
gold, buy, action, draw, vp, cost, name  out  field widths  registered decoded fields.
total_gold, total_buy, total_action, total_draw, total_vp  out  TOT_W each  running turn totals.
card_count  out  TOT_W  cards accepted this turn.
turn_done  out  1  one-cycle pulse when a turn closes.
busy  out  1  high in TURN state.

Function
REQ-007 FSM states IDLE, TURN, DONE; reset state IDLE.
REQ-008 IDLE: turn_start -> TURN; all other inputs ignored.
REQ-009 TURN: turn_end -> DONE; turn_start without turn_end -> stay in TURN, totals and card_count cleared.
REQ-010 TURN: turn_start and turn_end in the same cycle -> turn_end wins.
REQ-011 DONE lasts exactly one cycle, asserts turn_done, then -> IDLE; totals held until the next turn_start.
REQ-012 card_ready = (state==TURN) && (!out_valid || out_ready); combinational; never depends on card_valid.
REQ-013 Accept occurs on a cycle with card_valid && card_ready.
REQ-014 On accept, field outputs load the slices of card_data and out_valid sets on the next edge; latency 1 cycle.
REQ-015 out_valid clears on out_valid && out_ready with no accept in the same cycle; a simultaneous accept keeps out_valid high with the new fields (full throughput).
REQ-016 While out_valid && !out_ready, field outputs are held stable.
REQ-017 On accept with endgame=0: total_gold += gold field; total_vp += vp field.
REQ-018 On accept with endgame=1: total_gold unchanged; total_vp += gold field + vp field.
REQ-019 On accept, in both modes: total_buy, total_action and total_draw add their fields; card_count += 1.
REQ-020 All fields are zero-extended to TOT_W; every total and card_count saturates at 2^TOT_W-1 with no wrap.
REQ-021 turn_start while in TURN with an accept in the same cycle: totals = that card's contribution only; card_count = 1.
REQ-022 Totals update on the same edge that loads the field outputs.
REQ-023 A card accepted on the turn_end cycle is counted; from DONE onward card_ready=0.

Reset
REQ-024 rst asserted, asynchronously: state=IDLE; out_valid, turn_done, busy, all fields, all totals and card_count = 0.
REQ-025 rst mid-turn drops any held output word; there is no recovery of partial totals.

Configuration
REQ-026 Macro CARD_DECODE_TOTALS_EN defined: running totals, card_count and saturation logic are compiled in, per REQ-017 to REQ-021.
REQ-027 Macro CARD_DECODE_TOTALS_EN undefined: the total_* and card_count ports remain present, tied to 0; the FSM, handshake and field decode are unchanged.

Verification
REQ-028 Defaults, turn_start, accept card_data=30'h0A5C_5104 -> next cycle gold=5, buy=1, action=3, draw=4, vp=5, cost=1, name=8'h04; total_gold=5.
REQ-029 out_ready=0, two cards offered -> second card stalls with card_ready=0, fields hold the first card; out_ready=1 -> second card accepted the next cycle.
REQ-030 endgame=1, card with gold=3, vp=2 -> total_vp=5, total_gold=0.
REQ-031 TOT_W=4, 20 cards each with buy=1 -> total_buy=15, card_count=15, no wrap.
REQ-032 turn_end -> turn_done high for exactly 1 cycle, card_ready=0, state IDLE; totals held until turn_start clears them to 0.
REQ-033 rst pulsed mid-turn with out_valid=1 -> all outputs 0 immediately, without waiting for a clock edge.
